// File: rtl/rx_align_ctrl_if.sv
// Byte-side bundle between the deserializer and rx_align_ctrl.
// The slave modport is the controller view; the master modport is the source/monitor view.
interface rx_align_ctrl_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       slip;
  logic       active;
  logic [7:0] data_out;
  logic       valid_out;
  logic [3:0] BC_counter;
  logic [1:0] state;

  modport master (
    output data_in, valid_in,
    input  slip, active, data_out, valid_out, BC_counter, state
  );

  modport slave (
    input  data_in, valid_in,
    output slip, active, data_out, valid_out, BC_counter, state
  );
endinterface

// File: rtl/rx_align_ctrl.sv
// Comma-based symbol alignment and payload forwarding for the deserializer byte stream.
// Optional macro RX_BIT_SLIP_EN enables the timeout-driven bit-slip path and the SLIP_WAIT state.
module rx_align_ctrl #(
  parameter logic [7:0] BC_SYMBOL    = 8'hBC,
  parameter logic [7:0] IDLE_SYMBOL  = 8'h7C,
  parameter int         LOCK_COUNT   = 4,
  parameter int         SLIP_TIMEOUT = 8,
  parameter int         SLIP_HOLD    = 2,
  parameter int         BC_WINDOW    = 16
) (
  input  logic          clk_4f,
  input  logic          reset,
  rx_align_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_LOCKING   = 2'd1,
    ST_ACTIVE    = 2'd2,
    ST_SLIP_WAIT = 2'd3
  } state_t;

  localparam int              WIN_W    = $clog2(BC_WINDOW) + 1;
  localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(BC_WINDOW);
  localparam logic [4:0]       LOCK_MAX = 5'(LOCK_COUNT);

  if ((LOCK_COUNT < 32'sd1) || (LOCK_COUNT > 32'sd15) || (SLIP_TIMEOUT < 32'sd1) ||
      (SLIP_HOLD < 32'sd1) || (BC_WINDOW < 32'sd1)) begin : g_bad_cfg
    $error("rx_align_ctrl: parameter out of range");
  end

  state_t           state_q, state_d;
  logic [3:0]       bc_q, bc_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             slip_q, slip_d;
  logic             active_q, active_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;

  logic       sample_s, is_bc_s, is_idle_s;
  logic [3:0] bc_inc_s;
  logic       lock_hit_s, win_hit_s;
  logic       timeout_hit_s, hold_done_s;

  assign sample_s   = bus.valid_in;
  assign is_bc_s    = (bus.data_in == BC_SYMBOL);
  assign is_idle_s  = (bus.data_in == IDLE_SYMBOL);
  assign bc_inc_s   = (bc_q == 4'd15) ? 4'd15 : (bc_q + 4'd1);
  assign lock_hit_s = (({1'b0, bc_q} + 5'd1) >= LOCK_MAX);
  assign win_hit_s  = ((win_q + WIN_W'(1)) == WIN_MAX);

`ifdef RX_BIT_SLIP_EN
  localparam int               TO_W    = $clog2(SLIP_TIMEOUT) + 1;
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(SLIP_TIMEOUT);
  localparam int               HOLD_W  = $clog2(SLIP_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(SLIP_HOLD);

  logic [TO_W-1:0]   to_q, to_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Timeout counter idles at zero outside SEARCH; hold counter idles at zero outside SLIP_WAIT.
  always_comb begin
    timeout_hit_s = sample_s && (state_q == ST_SEARCH) && !is_bc_s &&
                    ((to_q + TO_W'(1)) == TO_MAX);
    hold_done_s   = sample_s && (state_q == ST_SLIP_WAIT) &&
                    ((hold_q + HOLD_W'(1)) == HOLD_MAX);
    if (state_q != ST_SEARCH) begin
      to_d = {TO_W{1'b0}};
    end else if (!sample_s) begin
      to_d = to_q;
    end else if (is_bc_s || timeout_hit_s) begin
      to_d = {TO_W{1'b0}};
    end else begin
      to_d = to_q + TO_W'(1);
    end
    if (state_q != ST_SLIP_WAIT) begin
      hold_d = {HOLD_W{1'b0}};
    end else if (!sample_s) begin
      hold_d = hold_q;
    end else if (hold_done_s) begin
      hold_d = {HOLD_W{1'b0}};
    end else begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  // Slip timing counters.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      to_q   <= {TO_W{1'b0}};
      hold_q <= {HOLD_W{1'b0}};
    end else begin
      to_q   <= to_d;
      hold_q <= hold_d;
    end
  end
`else
  // Without bit-slip SEARCH never times out and SLIP_WAIT cannot be entered.
  always_comb begin
    timeout_hit_s = 1'b0;
    hold_done_s   = 1'b1;
  end
`endif

  // State register.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q <= ST_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEARCH: begin
        if (!sample_s) begin
          state_d = ST_SEARCH;
        end else if (is_bc_s) begin
          state_d = (LOCK_MAX <= 5'd1) ? ST_ACTIVE : ST_LOCKING;
        end else if (timeout_hit_s) begin
          state_d = ST_SLIP_WAIT;
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_LOCKING: begin
        if (!sample_s) begin
          state_d = ST_LOCKING;
        end else if (!is_bc_s) begin
          state_d = ST_SEARCH;
        end else if (lock_hit_s) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_LOCKING;
        end
      end
      ST_ACTIVE: begin
        if (sample_s && !is_bc_s && win_hit_s) begin
          state_d = ST_SEARCH;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_SLIP_WAIT: begin
        if (hold_done_s) begin
          state_d = ST_SEARCH;
        end else begin
          state_d = ST_SLIP_WAIT;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Outputs and counters; the last forwarded byte is retained while valid_out is low.
  always_comb begin
    bc_d     = bc_q;
    win_d    = win_q;
    slip_d   = timeout_hit_s;
    valid_d  = 1'b0;
    data_d   = data_q;
    active_d = (state_d == ST_ACTIVE);
    if (sample_s) begin
      case (state_q)
        ST_SEARCH: begin
          if (is_bc_s) begin
            bc_d  = 4'd1;
            win_d = {WIN_W{1'b0}};
          end else begin
            bc_d = 4'd0;
          end
        end
        ST_LOCKING: begin
          if (is_bc_s) begin
            bc_d = bc_inc_s;
          end else begin
            bc_d = 4'd0;
          end
        end
        ST_ACTIVE: begin
          if (is_bc_s) begin
            bc_d  = bc_inc_s;
            win_d = {WIN_W{1'b0}};
          end else if (is_idle_s) begin
            bc_d  = 4'd0;
            win_d = win_q + WIN_W'(1);
          end else begin
            bc_d    = 4'd0;
            win_d   = win_q + WIN_W'(1);
            valid_d = 1'b1;
            data_d  = bus.data_in;
          end
          if (state_d == ST_SEARCH) begin
            win_d = {WIN_W{1'b0}};
          end else begin
            win_d = win_d;
          end
        end
        ST_SLIP_WAIT: bc_d = 4'd0;
        default:      bc_d = 4'd0;
      endcase
    end else begin
      bc_d = bc_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      bc_q     <= 4'd0;
      win_q    <= {WIN_W{1'b0}};
      slip_q   <= 1'b0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      bc_q     <= bc_d;
      win_q    <= win_d;
      slip_q   <= slip_d;
      active_q <= active_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign bus.slip       = slip_q;
  assign bus.active     = active_q;
  assign bus.data_out   = data_q;
  assign bus.valid_out  = valid_q;
  assign bus.BC_counter = bc_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_rx_align_ctrl.sv
// Directed-vector bench for rx_align_ctrl; the slip section follows RX_BIT_SLIP_EN.
module tb_rx_align_ctrl;
  logic clk_4f = 1'b0;
  logic reset;

  rx_align_ctrl_if bus_if ();

  rx_align_ctrl dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus_if.slave)
  );

  always #5 clk_4f = ~clk_4f;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [1:0] st, input logic [3:0] bc,
                        input logic act, input logic vo, input logic slp);
    chk({tag, ".state"},  32'(bus_if.state),      32'(st));
    chk({tag, ".bc"},     32'(bus_if.BC_counter), 32'(bc));
    chk({tag, ".active"}, 32'(bus_if.active),     32'(act));
    chk({tag, ".valid"},  32'(bus_if.valid_out),  32'(vo));
    chk({tag, ".slip"},   32'(bus_if.slip),       32'(slp));
  endtask

  task automatic cyc(input logic [7:0] d, input logic v);
    bus_if.data_in  = d;
    bus_if.valid_in = v;
    @(posedge clk_4f);
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    bus_if.data_in  = 8'h00;
    bus_if.valid_in = 1'b0;
    #12;
    chk_st("rst", 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("rst.data", 32'(bus_if.data_out), 32'h00);
    reset = 1'b0;

    // Four commas lock the link.
    for (int i = 1; i <= 4; i++) begin
      cyc(8'hBC, 1'b1);
      if (i < 4) chk_st($sformatf("lock%0d", i), 2'd1, 4'(i), 1'b0, 1'b0, 1'b0);
      else       chk_st("lock4", 2'd2, 4'd4, 1'b1, 1'b0, 1'b0);
    end

    // Forwarding with gaps: FF, BC, 7C, EE.
    cyc(8'hFF, 1'b1); chk_st("fwd_ff", 2'd2, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("fwd_ff.data", 32'(bus_if.data_out), 32'hFF);
    cyc(8'h00, 1'b0); chk_st("gap1", 2'd2, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("gap1.data", 32'(bus_if.data_out), 32'hFF);
    cyc(8'hBC, 1'b1); chk_st("fwd_bc", 2'd2, 4'd1, 1'b1, 1'b0, 1'b0);
    cyc(8'h12, 1'b0); chk_st("gap2", 2'd2, 4'd1, 1'b1, 1'b0, 1'b0);
    cyc(8'h7C, 1'b1); chk_st("fwd_idle", 2'd2, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("fwd_idle.data", 32'(bus_if.data_out), 32'hFF);
    cyc(8'hEE, 1'b1); chk_st("fwd_ee", 2'd2, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("fwd_ee.data", 32'(bus_if.data_out), 32'hEE);
    cyc(8'h00, 1'b0); chk_st("gap3", 2'd2, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("gap3.data", 32'(bus_if.data_out), 32'hEE);

    // Window loss: BC, then 16 non-comma bytes.
    cyc(8'hBC, 1'b1); chk_st("win_bc", 2'd2, 4'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      cyc(8'hFF, 1'b1);
      if (i < 16) chk_st($sformatf("win%0d", i), 2'd2, 4'd0, 1'b1, 1'b1, 1'b0);
      else        chk_st("win16", 2'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    end
    cyc(8'hFF, 1'b1); chk_st("win_after", 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Broken lock attempt: BC, BC, 00, BC.
    cyc(8'hBC, 1'b1); chk_st("brk1", 2'd1, 4'd1, 1'b0, 1'b0, 1'b0);
    cyc(8'hBC, 1'b1); chk_st("brk2", 2'd1, 4'd2, 1'b0, 1'b0, 1'b0);
    cyc(8'h00, 1'b1); chk_st("brk3", 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(8'hBC, 1'b1); chk_st("brk4", 2'd1, 4'd1, 1'b0, 1'b0, 1'b0);
    cyc(8'h00, 1'b1); chk_st("brk5", 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Eight non-comma bytes in SEARCH, with a hold gap after the fourth.
    for (int i = 1; i <= 8; i++) begin
      cyc(8'h55, 1'b1);
      if (i == 4) begin
        cyc(8'hBC, 1'b0); chk_st("to_gap", 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      end
`ifdef RX_BIT_SLIP_EN
      if (i < 8) chk_st($sformatf("to%0d", i), 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      else       chk_st("to8", 2'd3, 4'd0, 1'b0, 1'b0, 1'b1);
`else
      chk_st($sformatf("to%0d", i), 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
`endif
    end
`ifdef RX_BIT_SLIP_EN
    cyc(8'hBC, 1'b1); chk_st("hold1", 2'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(8'hBC, 1'b1); chk_st("hold2", 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
`endif
    cyc(8'hBC, 1'b1); chk_st("relock1", 2'd1, 4'd1, 1'b0, 1'b0, 1'b0);
    cyc(8'hBC, 1'b1);
    cyc(8'hBC, 1'b1);
    cyc(8'hBC, 1'b1); chk_st("relock4", 2'd2, 4'd4, 1'b1, 1'b0, 1'b0);
    cyc(8'h3C, 1'b1); chk_st("pre_rst", 2'd2, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("pre_rst.data", 32'(bus_if.data_out), 32'h3C);

    // Asynchronous reset between clock edges.
    bus_if.valid_in = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_st("async_rst", 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("async_rst.data", 32'(bus_if.data_out), 32'h00);
    #10;
    reset = 1'b0;
    cyc(8'hBC, 1'b0); chk_st("post_rst", 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/rx_align_ctrl.md
Name: rx_align_ctrl

Overview:
Symbol-alignment controller for the serial-to-parallel receive path. Sits on the byte side of the deserializer in the clk_4f domain. Watches deserialized bytes for the BC comma symbol and declares the link active after consecutive BCs. Commands bit-slip to the deserializer when no comma is found, and forwards payload bytes with BC/IDLE symbols stripped.

Parameters:
BC_SYMBOL, 8'hBC, comma symbol used for alignment
IDLE_SYMBOL, 8'h7C, idle filler symbol, dropped in ACTIVE
LOCK_COUNT, 4, consecutive BCs required to enter ACTIVE (1..15)
SLIP_TIMEOUT, 8, valid non-BC bytes in SEARCH before a slip request
SLIP_HOLD, 2, valid bytes discarded after a slip while the deserializer re-frames
BC_WINDOW, 16, max valid bytes in ACTIVE without a BC before lock is lost

Ports:
clk_4f  in  1  byte clock; all logic on rising edge
reset  in  1  asynchronous, active-high
data_in  in  8  byte from deserializer
valid_in  in  1  data_in qualifier
slip  out  1  one-cycle pulse: deserializer shifts its byte boundary by one bit
active  out  1  link aligned (state ACTIVE)
data_out  out  8  forwarded payload byte
valid_out  out  1  data_out qualifier
BC_counter  out  4  consecutive-BC count, saturating at 15
state  out  2  debug: 0 SEARCH, 1 LOCKING, 2 ACTIVE, 3 SLIP_WAIT

Behaviour:
- Clock and reset: one clock, clk_4f. Reset is asynchronous and active-high. Reset dominates every other event.
- Reset values: all outputs 0, state SEARCH, all internal counters 0.
- Input qualification: a byte is "sampled" only when valid_in=1. With valid_in=0, state and all counters hold and valid_out=0.
- BC_counter:
  - +1 per sampled BC, saturating at 15.
  - Cleared on any sampled non-BC byte and on entry to SEARCH or SLIP_WAIT.
  - IDLE in ACTIVE also clears it.
- SEARCH:
  - Sampled BC -> LOCKING, BC_counter=1, timeout counter cleared.
  - Sampled non-BC -> timeout counter +1.
  - When the count reaches SLIP_TIMEOUT: slip=1 for exactly one cycle (registered, the cycle after the SLIP_TIMEOUT-th byte), then -> SLIP_WAIT.
- SLIP_WAIT:
  - Discards SLIP_HOLD sampled bytes regardless of value, including BC.
  - Then -> SEARCH with the timeout counter cleared.
- LOCKING:
  - Sampled BC -> counter +1.
  - When BC_counter reaches LOCK_COUNT -> ACTIVE. active=1 the cycle after the LOCK_COUNT-th BC is sampled.
  - Sampled non-BC -> SEARCH; no slip is issued.
- ACTIVE:
  - BC: not forwarded; window counter cleared.
  - IDLE: not forwarded; window counter +1.
  - Other bytes: data_out<=data_in and valid_out=1 the next cycle (latency 1); window counter +1.
  - Window counter reaching BC_WINDOW without a BC -> SEARCH, active=0 next cycle, no forwarding from that cycle on.
- data_out holds its last value when valid_out=0.
- Out of ACTIVE, valid_out is always 0.
- slip is never asserted outside the SEARCH->SLIP_WAIT transition.
- Back-to-back slips are allowed: SEARCH timeout -> SLIP_WAIT -> SEARCH -> timeout again.
- Counter widths sized by $clog2 of each parameter + 1; no wrap, only compare-and-clear.

Optional Feature:
- Macro: RX_BIT_SLIP_EN.
- Defined: slip logic, timeout counter and SLIP_WAIT state exactly as described above.
- Undefined: slip is tied to 0, SLIP_WAIT is unreachable and the timeout counter is removed. SEARCH waits indefinitely for a BC. All other behaviour is unchanged.

Test Plan:
- Reset, then bytes BC,BC,BC,BC with valid_in=1 -> BC_counter 1,2,3,4; state LOCKING then ACTIVE; active=1 the cycle after the 4th BC; valid_out stays 0.
- Bytes BC,BC,00,BC -> BC_counter 1,2,0,1; state returns to SEARCH after the 00, then LOCKING; active never 1.
- In ACTIVE: FF,BC,7C,EE (valid_out checked with valid_in gaps inserted) -> exactly two valid_out pulses, data_out FF then EE, each one cycle after its input.
- RX_BIT_SLIP_EN defined, SEARCH, eight bytes of 55 -> one-cycle slip pulse after the 8th byte. The next two bytes (BC,BC) are ignored and BC_counter stays 0. The following BC enters LOCKING.
- In ACTIVE, 16 bytes of FF with no BC -> active falls the cycle after the 16th, state=SEARCH, and only the 16 FF bytes are forwarded.
- Assert reset mid-ACTIVE, between clock edges -> active, valid_out, slip, BC_counter and state go to 0 immediately without a clk_4f edge.
